// File: rtl/bsg_blackparrot_io_word_serializer_pkg.sv
// Shared types for the BlackParrot I/O dword-to-word serializer.
package bsg_blackparrot_io_serializer_pkg;

  typedef enum logic [1:0] {
    e_size_1B = 2'd0,
    e_size_2B = 2'd1,
    e_size_4B = 2'd2,
    e_size_8B = 2'd3
  } bp_io_size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } ser_state_e;

  localparam int unsigned word_offset_gp = 4;

endpackage

// File: rtl/bsg_blackparrot_io_word_serializer_if.sv
// Command/response channels of the serializer; master = serializer side, slave = surrounding system.
interface bsg_blackparrot_io_word_serializer_if #(
  parameter int paddr_width_p   = 40,
  parameter int payload_width_p = 32
);
  logic [paddr_width_p-1:0]   cmd_addr_i;
  logic [1:0]                 cmd_size_i;
  logic                       cmd_wr_i;
  logic [payload_width_p-1:0] cmd_payload_i;
  logic [63:0]                cmd_data_i;
  logic                       cmd_v_i;
  logic                       cmd_ready_and_o;

  logic [paddr_width_p-1:0]   word_cmd_addr_o;
  logic [1:0]                 word_cmd_size_o;
  logic                       word_cmd_wr_o;
  logic [payload_width_p-1:0] word_cmd_payload_o;
  logic [31:0]                word_cmd_data_o;
  logic                       word_cmd_v_o;
  logic                       word_cmd_ready_and_i;

  logic [payload_width_p-1:0] word_resp_payload_i;
  logic [31:0]                word_resp_data_i;
  logic                       word_resp_v_i;
  logic                       word_resp_yumi_o;

  logic [payload_width_p-1:0] resp_payload_o;
  logic [63:0]                resp_data_o;
  logic                       resp_v_o;
  logic                       resp_ready_and_i;

  modport master (
    input  cmd_addr_i, cmd_size_i, cmd_wr_i, cmd_payload_i, cmd_data_i, cmd_v_i,
    output cmd_ready_and_o,
    output word_cmd_addr_o, word_cmd_size_o, word_cmd_wr_o, word_cmd_payload_o,
           word_cmd_data_o, word_cmd_v_o,
    input  word_cmd_ready_and_i,
    input  word_resp_payload_i, word_resp_data_i, word_resp_v_i,
    output word_resp_yumi_o,
    output resp_payload_o, resp_data_o, resp_v_o,
    input  resp_ready_and_i
  );

  modport slave (
    output cmd_addr_i, cmd_size_i, cmd_wr_i, cmd_payload_i, cmd_data_i, cmd_v_i,
    input  cmd_ready_and_o,
    input  word_cmd_addr_o, word_cmd_size_o, word_cmd_wr_o, word_cmd_payload_o,
           word_cmd_data_o, word_cmd_v_o,
    output word_cmd_ready_and_i,
    output word_resp_payload_i, word_resp_data_i, word_resp_v_i,
    input  word_resp_yumi_o,
    input  resp_payload_o, resp_data_o, resp_v_o,
    output resp_ready_and_i
  );

endinterface

// File: rtl/bsg_blackparrot_io_resp_merge.sv
// Response side: split-flag FIFO, low-half holding register and 1-entry merged output register.
module bsg_blackparrot_io_resp_merge #(
  parameter int payload_width_p   = 32,
  parameter int max_outstanding_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic                       flag_v_i,
  input  logic                       flag_split_i,
  output logic                       flag_ready_o,

  input  logic [payload_width_p-1:0] word_resp_payload_i,
  input  logic [31:0]                word_resp_data_i,
  input  logic                       word_resp_v_i,
  output logic                       word_resp_yumi_o,

  output logic [payload_width_p-1:0] resp_payload_o,
  output logic [63:0]                resp_data_o,
  output logic                       resp_v_o,
  input  logic                       resp_ready_and_i
);
  logic        head_v, head_split, flag_pop;
  logic        half_v, first_half, final_word;
  logic [31:0] half_r;

  bsg_fifo_1r1w_small #(
    .width_p (1),
    .els_p   (max_outstanding_p)
  ) flag_fifo (
    .clk_i   (clk_i),
    .reset_i (~reset_n_i),
    .v_i     (flag_v_i),
    .ready_o (flag_ready_o),
    .data_i  (flag_split_i),
    .v_o     (head_v),
    .data_o  (head_split),
    .yumi_i  (flag_pop)
  );

  // The low half never touches the output register, so it may be taken while that register is stalled.
  assign first_half       = head_split & ~half_v;
  assign word_resp_yumi_o = reset_n_i & word_resp_v_i & head_v
                          & (~resp_v_o | resp_ready_and_i | first_half);
  assign final_word       = word_resp_yumi_o & ~first_half;
  assign flag_pop         = final_word;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      half_v         <= 1'b0;
      half_r         <= '0;
      resp_v_o       <= 1'b0;
      resp_data_o    <= '0;
      resp_payload_o <= '0;
    end else begin
      if (word_resp_yumi_o & first_half) begin
        half_r <= word_resp_data_i;
        half_v <= 1'b1;
      end
      if (final_word) begin
        resp_data_o    <= {word_resp_data_i, head_split ? half_r : word_resp_data_i};
        resp_payload_o <= word_resp_payload_i;
        resp_v_o       <= 1'b1;
        half_v         <= 1'b0;
      end else if (resp_ready_and_i) begin
        resp_v_o <= 1'b0;
      end
    end
  end

  a_resp_without_cmd: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(word_resp_v_i && !head_v));

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO; push while full is legal only together with a pop.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 1,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   rptr, wptr;
  logic [cnt_w-1:0]   count;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (v_i)    wptr <= ptr_inc(wptr);
      if (yumi_i) rptr <= ptr_inc(rptr);
      if (v_i & ~yumi_i)      count <= count + cnt_w'(1);
      else if (~v_i & yumi_i) count <= count - cnt_w'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (v_i) mem[wptr] <= data_i;
  end

  assign v_o     = (count != '0);
  assign ready_o = (count != full_cnt);
  assign data_o  = mem[rptr];

endmodule

// File: rtl/bsg_blackparrot_io_word_serializer.sv
// Splits 8B I/O commands into two word beats and merges their responses into one dword.
// Optional sticky alignment checker enabled by BSG_IO_SERIALIZER_MISALIGN_ERR_EN.
module bsg_blackparrot_io_word_serializer
  import bsg_blackparrot_io_serializer_pkg::*;
#(
  parameter int paddr_width_p     = 40,
  parameter int payload_width_p   = 32,
  parameter int max_outstanding_p = 8
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_blackparrot_io_word_serializer_if.master io
`ifdef BSG_IO_SERIALIZER_MISALIGN_ERR_EN
  ,
  output logic misalign_err_o
`endif
);
  ser_state_e                 state_r, state_n;
  logic [paddr_width_p-1:0]   held_addr;
  bp_io_size_e                held_size;
  logic                       held_wr, held_split;
  logic [payload_width_p-1:0] held_payload;
  logic [63:0]                held_data;

  logic                       word_v, final_beat, cmd_ready, accept, flag_ready;
  logic [paddr_width_p-1:0]   word_addr;
  logic [31:0]                word_data;
  bp_io_size_e                word_size;

  always_comb begin
    state_n    = state_r;
    word_v     = 1'b0;
    final_beat = 1'b0;
    word_addr  = held_addr;
    word_data  = held_data[31:0];
    word_size  = held_split ? e_size_4B : held_size;
    unique case (state_r)
      S_LO: begin
        word_v = 1'b1;
        if (io.word_cmd_ready_and_i) begin
          final_beat = ~held_split;
          state_n    = held_split ? S_HI : S_IDLE;
        end
      end
      S_HI: begin
        word_v    = 1'b1;
        word_addr = held_addr + paddr_width_p'(word_offset_gp);
        word_data = held_data[63:32];
        word_size = e_size_4B;
        if (io.word_cmd_ready_and_i) begin
          final_beat = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default: ;
    endcase
    // A new command may be taken on the cycle the last beat of the current one leaves.
    cmd_ready = reset_n_i & flag_ready & ((state_r == S_IDLE) | final_beat);
    accept    = io.cmd_v_i & cmd_ready;
    if (accept) state_n = S_LO;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r      <= S_IDLE;
      held_addr    <= '0;
      held_size    <= e_size_1B;
      held_wr      <= 1'b0;
      held_split   <= 1'b0;
      held_payload <= '0;
      held_data    <= '0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        held_addr    <= io.cmd_addr_i;
        held_size    <= bp_io_size_e'(io.cmd_size_i);
        held_wr      <= io.cmd_wr_i;
        held_split   <= (io.cmd_size_i == e_size_8B);
        held_payload <= io.cmd_payload_i;
        held_data    <= io.cmd_data_i;
      end
    end
  end

  assign io.cmd_ready_and_o    = cmd_ready;
  assign io.word_cmd_v_o       = word_v & reset_n_i;
  assign io.word_cmd_addr_o    = word_addr;
  assign io.word_cmd_size_o    = word_size;
  assign io.word_cmd_wr_o      = held_wr;
  assign io.word_cmd_payload_o = held_payload;
  assign io.word_cmd_data_o    = word_data;

  bsg_blackparrot_io_resp_merge #(
    .payload_width_p   (payload_width_p),
    .max_outstanding_p (max_outstanding_p)
  ) resp_merge (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .flag_v_i            (accept),
    .flag_split_i        (io.cmd_size_i == e_size_8B),
    .flag_ready_o        (flag_ready),
    .word_resp_payload_i (io.word_resp_payload_i),
    .word_resp_data_i    (io.word_resp_data_i),
    .word_resp_v_i       (io.word_resp_v_i),
    .word_resp_yumi_o    (io.word_resp_yumi_o),
    .resp_payload_o      (io.resp_payload_o),
    .resp_data_o         (io.resp_data_o),
    .resp_v_o            (io.resp_v_o),
    .resp_ready_and_i    (io.resp_ready_and_i)
  );

`ifdef BSG_IO_SERIALIZER_MISALIGN_ERR_EN
  logic misaligned;
  assign misaligned = ((io.cmd_size_i == e_size_8B) & (|io.cmd_addr_i[2:0]))
                    | ((io.cmd_size_i == e_size_4B) & (|io.cmd_addr_i[1:0]));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)              misalign_err_o <= 1'b0;
    else if (accept & misaligned) misalign_err_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bsg_blackparrot_io_word_serializer.sv
// Directed and randomized bench for the I/O word serializer against a transaction-level scoreboard.
`timescale 1ns/1ps
module tb_bsg_blackparrot_io_word_serializer;
  localparam int PA = 40;
  localparam int PL = 32;
  localparam int MO = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bsg_blackparrot_io_word_serializer_if #(.paddr_width_p(PA), .payload_width_p(PL)) io ();

`ifdef BSG_IO_SERIALIZER_MISALIGN_ERR_EN
  logic misalign_err;
  bsg_blackparrot_io_word_serializer #(
    .paddr_width_p(PA), .payload_width_p(PL), .max_outstanding_p(MO)
  ) dut (.clk_i(clk), .reset_n_i(reset_n), .io(io), .misalign_err_o(misalign_err));
`else
  bsg_blackparrot_io_word_serializer #(
    .paddr_width_p(PA), .payload_width_p(PL), .max_outstanding_p(MO)
  ) dut (.clk_i(clk), .reset_n_i(reset_n), .io(io));
`endif

  typedef struct {
    logic [PA-1:0] addr; logic [1:0] size; logic wr; logic [PL-1:0] pl;
    logic [63:0] data; logic [31:0] rlo; logic [31:0] rhi;
  } cmd_t;
  typedef struct {
    logic [PA-1:0] addr; logic [1:0] size; logic wr; logic [PL-1:0] pl; logic [31:0] data;
  } beat_t;
  typedef struct { logic [PL-1:0] pl; logic [31:0] data; } word_t;
  typedef struct { logic [PL-1:0] pl; logic [63:0] data; } resp_t;

  cmd_t  cmd_q[$];
  beat_t exp_beat_q[$];
  word_t rword_q[$];
  resp_t exp_resp_q[$];

  int errors = 0, checks = 0, cyc = 0;
  int beats_seen = 0, words_sent = 0, n_acc = 0, n_resp = 0;
  int acc_cyc = 0, beat_cyc = 0, yumi_cyc = 0, resp_cyc = 0;
  int unsigned cmd_pct = 100, wr_pct = 100, rv_pct = 100, rr_pct = 100;
  beat_t last_beat;
  resp_t last_resp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [PA-1:0] a, input logic [1:0] s, input logic w,
                              input logic [PL-1:0] p, input logic [63:0] d,
                              input logic [31:0] lo, input logic [31:0] hi);
    cmd_t c;
    c.addr = a; c.size = s; c.wr = w; c.pl = p; c.data = d; c.rlo = lo; c.rhi = hi;
    return c;
  endfunction

  // Transaction model: an 8B command becomes two 4B beats (addr, addr+4) and one merged response.
  task automatic model_accept(input cmd_t c);
    beat_t b;
    word_t w;
    resp_t r;
    b.addr = c.addr; b.wr = c.wr; b.pl = c.pl; b.data = c.data[31:0];
    w.pl = c.pl; r.pl = c.pl;
    if (c.size == 2'd3) begin
      b.size = 2'd2;
      exp_beat_q.push_back(b);
      b.addr = c.addr + PA'(4);
      b.data = c.data[63:32];
      exp_beat_q.push_back(b);
      w.data = c.rlo; rword_q.push_back(w);
      w.data = c.rhi; rword_q.push_back(w);
      r.data = {c.rhi, c.rlo};
    end else begin
      b.size = c.size;
      exp_beat_q.push_back(b);
      w.data = c.rlo; rword_q.push_back(w);
      r.data = {c.rlo, c.rlo};
    end
    exp_resp_q.push_back(r);
  endtask

  task automatic step();
    beat_t b;
    resp_t r;
    @(negedge clk);
    io.cmd_v_i = (cmd_q.size() != 0) && ($urandom_range(99) < cmd_pct);
    if (cmd_q.size() != 0) begin
      io.cmd_addr_i = cmd_q[0].addr; io.cmd_size_i = cmd_q[0].size; io.cmd_wr_i = cmd_q[0].wr;
      io.cmd_payload_i = cmd_q[0].pl; io.cmd_data_i = cmd_q[0].data;
    end
    io.word_cmd_ready_and_i = ($urandom_range(99) < wr_pct);
    io.word_resp_v_i = (rword_q.size() != 0) && (words_sent < beats_seen)
                       && ($urandom_range(99) < rv_pct);
    if (rword_q.size() != 0) begin
      io.word_resp_payload_i = rword_q[0].pl; io.word_resp_data_i = rword_q[0].data;
    end
    io.resp_ready_and_i = ($urandom_range(99) < rr_pct);
    #1;
    if (io.word_cmd_v_o && io.word_cmd_ready_and_i) begin
      if (exp_beat_q.size() == 0) check("wc_unexpected", 64'(io.word_cmd_v_o), 0);
      else begin
        b = exp_beat_q.pop_front();
        check("wc_addr", 64'(io.word_cmd_addr_o), 64'(b.addr));
        check("wc_size", 64'(io.word_cmd_size_o), 64'(b.size));
        check("wc_wr", 64'(io.word_cmd_wr_o), 64'(b.wr));
        check("wc_payload", 64'(io.word_cmd_payload_o), 64'(b.pl));
        check("wc_data", 64'(io.word_cmd_data_o), 64'(b.data));
      end
      last_beat.addr = io.word_cmd_addr_o; last_beat.size = io.word_cmd_size_o;
      last_beat.data = io.word_cmd_data_o;
      beats_seen++; beat_cyc = cyc;
    end
    if (io.word_resp_v_i && io.word_resp_yumi_o) begin
      void'(rword_q.pop_front());
      words_sent++; yumi_cyc = cyc;
    end
    if (io.resp_v_o && io.resp_ready_and_i) begin
      if (exp_resp_q.size() == 0) check("resp_unexpected", 64'(io.resp_v_o), 0);
      else begin
        r = exp_resp_q.pop_front();
        check("resp_payload", 64'(io.resp_payload_o), 64'(r.pl));
        check("resp_data", io.resp_data_o, r.data);
      end
      last_resp.pl = io.resp_payload_o; last_resp.data = io.resp_data_o;
      n_resp++; resp_cyc = cyc;
    end
    if (io.cmd_v_i && io.cmd_ready_and_o) begin
      model_accept(cmd_q.pop_front());
      n_acc++; acc_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while ((cmd_q.size() + exp_beat_q.size() + exp_resp_q.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drain"}, 64'(cmd_q.size() + exp_beat_q.size() + exp_resp_q.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    io.cmd_v_i = 1'b0; io.word_cmd_ready_and_i = 1'b0; io.word_resp_v_i = 1'b0;
    io.resp_ready_and_i = 1'b0;
    cmd_q.delete(); exp_beat_q.delete(); rword_q.delete(); exp_resp_q.delete();
    beats_seen = 0; words_sent = 0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(io.cmd_ready_and_o), 0);
    check("rst_word_cmd_v", 64'(io.word_cmd_v_o), 0);
    check("rst_yumi", 64'(io.word_resp_yumi_o), 0);
    check("rst_resp_v", 64'(io.resp_v_o), 0);
    reset_n = 1'b1;
    #1;
    check("rst_release_ready", 64'(io.cmd_ready_and_o), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b0, a0, r0, w0;
    cmd_t c;
    logic [63:0] rnd;
    io.cmd_v_i = 1'b0; io.cmd_addr_i = '0; io.cmd_size_i = '0; io.cmd_wr_i = 1'b0;
    io.cmd_payload_i = '0; io.cmd_data_i = '0;
    io.word_cmd_ready_and_i = 1'b0; io.word_resp_v_i = 1'b0;
    io.word_resp_payload_i = '0; io.word_resp_data_i = '0; io.resp_ready_and_i = 1'b0;

    do_reset();

    // 4B store passthrough.
    cmd_q.push_back(mk(40'h1000, 2'd2, 1'b1, 32'hA5A5_0001, 64'hAAAA_BBBB_1234_5678,
                       32'hDEAD_0000, 32'h0));
    drain(50, "pass");
    check("pass_addr", 64'(last_beat.addr), 64'h1000);
    check("pass_size", 64'(last_beat.size), 2);
    check("pass_data", 64'(last_beat.data), 64'h1234_5678);
    check("pass_resp", last_resp.data, 64'hDEAD_0000_DEAD_0000);
    check("pass_beat_latency", 64'(beat_cyc - acc_cyc), 1);
    check("pass_resp_latency", 64'(resp_cyc - yumi_cyc), 1);

    // 8B load split into two words.
    cmd_q.push_back(mk(40'h2000, 2'd3, 1'b0, 32'h0000_0B0B, 64'h0,
                       32'h5566_7788, 32'h1122_3344));
    drain(50, "split");
    check("split_hi_addr", 64'(last_beat.addr), 64'h2004);
    check("split_hi_size", 64'(last_beat.size), 2);
    check("split_resp", last_resp.data, 64'h1122_3344_5566_7788);

    // Downstream backpressure while the high beat is pending.
    cmd_q.push_back(mk(40'h4000, 2'd3, 1'b1, 32'h0000_4444, 64'hCAFE_0001_BEEF_0002,
                       32'h0101_0101, 32'h0202_0202));
    cmd_q.push_back(mk(40'h5000, 2'd2, 1'b0, 32'h0000_5555, 64'h0, 32'h0303_0303, 32'h0));
    b0 = beats_seen; n = 0;
    while (beats_seen == b0 && n < 20) begin step(); n++; end
    check("bp_first_beat", 64'(beats_seen - b0), 1);
    wr_pct = 0; a0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_v", 64'(io.word_cmd_v_o), 1);
      check("bp_addr", 64'(io.word_cmd_addr_o), 64'h4004);
      check("bp_data", 64'(io.word_cmd_data_o), 64'hCAFE_0001);
      check("bp_cmd_ready", 64'(io.cmd_ready_and_o), 0);
    end
    check("bp_no_accept", 64'(n_acc - a0), 0);
    wr_pct = 100;
    drain(100, "bp");

    // Outstanding limit: eight splits fill the flag FIFO.
    rv_pct = 0;
    for (int i = 0; i < 9; i++)
      cmd_q.push_back(mk(40'h8000 + PA'(i * 16), 2'd3, 1'b0, PL'(i), 64'(i),
                         $urandom(), $urandom()));
    a0 = n_acc; n = 0;
    while (n_acc - a0 < 8 && n < 100) begin step(); n++; end
    repeat (6) step();
    check("lim_accepts", 64'(n_acc - a0), 8);
    check("lim_ready_full", 64'(io.cmd_ready_and_o), 0);
    rv_pct = 100; r0 = n_resp; n = 0;
    while (n_resp == r0 && n < 50) begin step(); n++; end
    check("lim_first_resp", 64'(n_resp - r0), 1);
    check("lim_ready_on_resp", 64'(io.cmd_ready_and_o), 1);
    drain(200, "lim");

    // Reset after the first half of a split response has been consumed.
    cmd_q.push_back(mk(40'h6000, 2'd3, 1'b0, 32'h0000_6666, 64'h0,
                       32'h1111_2222, 32'h3333_4444));
    w0 = words_sent; n = 0;
    while (words_sent == w0 && n < 20) begin step(); n++; end
    check("mr_first_half", 64'(words_sent - w0), 1);
    check("mr_no_resp_yet", 64'(io.resp_v_o), 0);
    do_reset();
    cmd_q.push_back(mk(40'h7000, 2'd2, 1'b0, 32'h0000_7777, 64'h0, 32'hCAFE_F00D, 32'h0));
    drain(50, "mr");
    check("mr_resp", last_resp.data, 64'hCAFE_F00D_CAFE_F00D);

`ifdef BSG_IO_SERIALIZER_MISALIGN_ERR_EN
    check("mis_clear", 64'(misalign_err), 0);
    cmd_q.push_back(mk(40'h3004, 2'd3, 1'b0, 32'h0000_3333, 64'h0, 32'h1, 32'h2));
    drain(50, "mis");
    check("mis_set", 64'(misalign_err), 1);
    check("mis_hi_addr", 64'(last_beat.addr), 64'h3008);
    repeat (3) step();
    check("mis_sticky", 64'(misalign_err), 1);
`endif

    // Randomized traffic with varying handshake pressure, including address wrap.
    for (int batch = 0; batch < 4; batch++) begin
      cmd_pct = $urandom_range(100, 30); wr_pct = $urandom_range(100, 30);
      rv_pct  = $urandom_range(100, 30); rr_pct = $urandom_range(100, 30);
      for (int i = 0; i < 60; i++) begin
        rnd = {$urandom(), $urandom()};
        c.addr = rnd[PA-1:0];
        if ($urandom_range(7) == 0) c.addr = {{(PA-3){1'b1}}, 3'b100};
        c.size = 2'($urandom_range(3));
        c.wr   = 1'($urandom_range(1));
        c.pl   = $urandom();
        c.data = {$urandom(), $urandom()};
        c.rlo  = $urandom();
        c.rhi  = $urandom();
        cmd_q.push_back(c);
      end
      drain(5000, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_blackparrot_io_word_serializer.md
Name: bsg_blackparrot_io_word_serializer

Overview:
- Sits between the BlackParrot unicore I/O command/response port (dword data) and the host-side command/manycore bridge (word data).
- Splits each 8-byte I/O command into two 4-byte word commands.
- Merges the two matching word responses back into one dword response.
- Commands of 4 bytes or less pass through as a single word beat.
- Restores the serialization stage in the unicore tile's host I/O path.

Parameters:
- paddr_width_p, 40, physical address width.
- payload_width_p, 32, opaque header payload (lce id, way, etc.); carried unchanged.
- max_outstanding_p, 8, maximum commands awaiting responses; depth of the split-flag FIFO.

Ports:
- clk_i  in  1  core clock.
- reset_n_i  in  1  synchronous active-low reset.
- cmd_addr_i  in  paddr_width_p  upstream command address.
- cmd_size_i  in  2  log2 bytes: 0=1B, 1=2B, 2=4B, 3=8B.
- cmd_wr_i  in  1  1=store, 0=load.
- cmd_payload_i  in  payload_width_p  opaque header payload.
- cmd_data_i  in  64  store data.
- cmd_v_i  in  1  upstream command valid.
- cmd_ready_and_o  out  1  upstream command ready.
- word_cmd_addr_o  out  paddr_width_p  downstream word command address.
- word_cmd_size_o  out  2  downstream word command size.
- word_cmd_wr_o  out  1  downstream store flag.
- word_cmd_payload_o  out  payload_width_p  downstream payload.
- word_cmd_data_o  out  32  downstream store data.
- word_cmd_v_o  out  1  downstream command valid.
- word_cmd_ready_and_i  in  1  downstream command ready.
- word_resp_payload_i  in  payload_width_p  word response payload.
- word_resp_data_i  in  32  word response data.
- word_resp_v_i  in  1  word response valid.
- word_resp_yumi_o  out  1  word response consumed.
- resp_payload_o  out  payload_width_p  merged response payload.
- resp_data_o  out  64  merged response data.
- resp_v_o  out  1  merged response valid.
- resp_ready_and_i  in  1  upstream response ready.

Behaviour:
- Reset (reset_n_i=0 at posedge):
  - Outputs: cmd_ready_and_o=0, word_cmd_v_o=0, word_resp_yumi_o=0, resp_v_o=0.
  - State: FSM to S_IDLE, flag FIFO emptied, half-word register cleared.
  - Any in-flight split or partial merge is discarded; no beat completes after reset.
- Command FSM, states S_IDLE, S_LO, S_HI:
  - Accept when cmd_v_i & cmd_ready_and_o.
  - cmd_ready_and_o = flag FIFO not full & (S_IDLE | final beat handshaking this cycle).
  - On accept: latch the command into a holding register, push split = (cmd_size_i==3) into the flag FIFO, go to S_LO.
  - Latency: first word beat is valid the cycle after accept.
- S_LO drives word_cmd_v_o=1:
  - Address = held addr; data = data[31:0]; size = 2 if split, else the held size; payload unchanged.
  - On word handshake: if split go to S_HI, else go to S_IDLE (or stay in S_LO if a new command is accepted the same cycle).
- S_HI drives word_cmd_v_o=1:
  - Address = held addr + 4 (paddr-width add, wraps modulo 2^paddr_width_p); data = data[63:32]; size = 2.
  - On handshake: same exit rule as S_LO.
- Word command fields are stable while word_cmd_v_o=1 and not ready.
- Response side: the flag FIFO head selects merge mode. A 1-entry output register holds resp_*.
  - word_resp_yumi_o = word_resp_v_i & flag FIFO nonempty & (output reg empty | resp_ready_and_i | merge is on its first half).
  - Non-split: output data = {word, word} (replicated); pop the flag.
  - Split, first word: store into the half register; no output, no pop.
  - Split, second word: output data = {word, half}; pop the flag.
  - resp_v_o is registered (1-cycle latency from the final word yumi); it clears on handshake unless reloaded the same cycle.
- Word responses arrive in command order.
- A word response that arrives with the flag FIFO empty is a protocol error: assertion in simulation, never yumi'd.
- Stores also return responses; they merge the same way, with data don't-care.
- Simultaneous FIFO push and pop in one cycle is legal, including when the FIFO is full.

Optional Feature:
- Macro: BSG_IO_SERIALIZER_MISALIGN_ERR_EN.
- When defined: adds output misalign_err_o (1 bit, reset 0). It sets sticky on acceptance of a size-3 command with addr[2:0]!=0, or a size-2 command with addr[1:0]!=0, and stays set until reset. The command is still forwarded unchanged.
- When undefined: no port, no check logic.

Decomposition:
- Package bsg_blackparrot_io_serializer_pkg holds:
  - the 2-bit size enum (e_size_1B..e_size_8B);
  - the FSM state enum;
  - the word byte-offset constant (4).
- Sub-module bsg_blackparrot_io_resp_merge holds the flag FIFO (built on bsg_fifo_1r1w_small), the half register and the output register.
- The top level keeps the command FSM.

Test Plan:
- Passthrough: 4B store addr 0x1000, data 0xAAAA_BBBB_1234_5678 -> one word cmd addr 0x1000 size 2 data 0x12345678. Its response 0xDEAD0000 -> resp_data_o=0xDEAD0000_DEAD0000.
- Split load: 8B load addr 0x2000 -> word cmds 0x2000 then 0x2004, both size 2. Responses 0x55667788 then 0x11223344 -> single resp_data_o=0x11223344_55667788.
- Downstream backpressure: word_cmd_ready_and_i=0 for 5 cycles in S_HI -> fields stable, cmd_ready_and_o=0, no duplicate beat.
- Outstanding limit: 8 split commands with no responses -> cmd_ready_and_o=0 on the 9th. First merged response returns -> cmd_ready_and_o=1 the same cycle.
- Reset mid-operation: reset_n_i=0 after the first half of a split response -> all valids 0. After release, a new 4B load completes with correct, unmerged data.
- Misalignment (macro on): 8B load addr 0x3004 -> misalign_err_o=1 from the next cycle and held; the command is still forwarded as 0x3004/0x3008.
